// File: rtl/ssaes_pkg.sv
// Shared constants, S-box tables and FSM state type for the Small Scale AES 4x4x4 datapath.
package ssaes_pkg;

  localparam int CELL_W    = 4;
  localparam int NUM_CELLS = 16;

  localparam logic [CELL_W-1:0] SBOX [0:NUM_CELLS-1] = '{
    4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
    4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8
  };

  localparam logic [CELL_W-1:0] INV_SBOX [0:NUM_CELLS-1] = '{
    4'hE, 4'hD, 4'h4, 4'hC, 4'h3, 4'h2, 4'h0, 4'h6,
    4'hF, 4'h8, 4'h7, 4'h1, 4'hB, 4'h9, 4'h5, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/ssaes_sbox_cell.sv
// Combinational 4-bit S-box; i_inv picks the inverse table.
module ssaes_sbox_cell
  import ssaes_pkg::*;
(
  input  logic [CELL_W-1:0] i_din,
  input  logic              i_inv,
  output logic [CELL_W-1:0] o_dout
);

  assign o_dout = i_inv ? INV_SBOX[i_din] : SBOX[i_din];

endmodule

// File: rtl/ssaes_sub_bytes_iter.sv
// Iterative SubBytes: NUM_SBOX S-boxes sweep the 16 cells of the state in 16/NUM_SBOX cycles,
// with valid/ready handshakes on both the input and the output side.
module ssaes_sub_bytes_iter
  import ssaes_pkg::*;
#(
  parameter int NUM_SBOX = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [NUM_CELLS*CELL_W-1:0] din,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CELLS*CELL_W-1:0] dout
);

  localparam int NUM_STEPS = NUM_CELLS / ((NUM_SBOX > 0) ? NUM_SBOX : 1);
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  generate
    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
          NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_badParam
      $error("ssaes_sub_bytes_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t r_fsm;
  state_t w_nextFsm;

  logic [NUM_CELLS*CELL_W-1:0] r_data;
  logic [NUM_CELLS*CELL_W-1:0] w_dataNext;
  logic                        r_modeInv;
  logic [CNT_W-1:0]            r_cnt;

  logic [3:0]        w_cellIdx [NUM_SBOX];
  logic [CELL_W-1:0] w_cellIn  [NUM_SBOX];
  logic [CELL_W-1:0] w_cellOut [NUM_SBOX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_nextFsm;
    end
  end

  always_comb begin
    w_nextFsm = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid)          w_nextFsm = BUSY;
      BUSY:    if (r_cnt == LAST_CNT) w_nextFsm = DONE;
      DONE:    if (out_ready)         w_nextFsm = IDLE;
      default:                        w_nextFsm = IDLE;
    endcase
  end

  // Group cnt owns cells cnt*NUM_SBOX .. cnt*NUM_SBOX+NUM_SBOX-1.
  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    assign w_cellIdx[j] = 4'(int'(r_cnt) * NUM_SBOX + j);
    assign w_cellIn[j]  = r_data[{w_cellIdx[j], 2'b00} +: CELL_W];

    ssaes_sbox_cell u_cell (
      .i_din  (w_cellIn[j]),
      .i_inv  (r_modeInv),
      .o_dout (w_cellOut[j])
    );
  end

  always_comb begin
    w_dataNext = r_data;
    for (int j = 0; j < NUM_SBOX; j++) begin
      w_dataNext[{w_cellIdx[j], 2'b00} +: CELL_W] = w_cellOut[j];
    end
  end

  // cnt saturates at LAST_CNT; it is cleared on each new acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_modeInv <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_data    <= din;
            r_modeInv <= in_inv;
            r_cnt     <= '0;
          end
        end
        BUSY: begin
          r_data <= w_dataNext;
          if (r_cnt != LAST_CNT) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign dout      = r_data;

endmodule
